// File: rtl/div.sv
// div: iterative RV32M DIV/DIVU/REM/REMU unit.
// Radix-2 restoring division, 32 BUSY cycles, one-cycle ready pulse.
module div (
  input  logic        rst,
  input  logic        clk,
  input  logic        div_enable,
  input  logic        div_clear,
  input  logic [31:0] div_rdata1,
  input  logic [31:0] div_rdata2,
  input  logic [3:0]  div_op,
  output logic [31:0] div_result,
  output logic        div_ready,
  output logic        div_busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] r_q, r_d;
  logic [31:0] q_q, q_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rem_q, rem_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;

  logic        sgn, is_rem, dz, ovf;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shl, t;
  logic [31:0] r_s, q_s, q_fin, r_fin;

  // op decode; op bits are {div, divu, rem, remu}
  assign sgn    = div_op[3] | div_op[1];
  assign is_rem = (div_op[1] | div_op[0]) & ~(div_op[3] | div_op[2]);
  assign abs_a  = (sgn & div_rdata1[31]) ? -div_rdata1 : div_rdata1;
  assign abs_b  = (sgn & div_rdata2[31]) ? -div_rdata2 : div_rdata2;
  assign dz     = (div_rdata2 == 32'd0);
  assign ovf    = sgn & (div_rdata1 == 32'h8000_0000)
                      & (div_rdata2 == 32'hFFFF_FFFF);

  // One restoring step. R stays below the divisor, so the
  // restore path always fits back into 32 bits.
  assign shl   = {r_q, q_q[31]};
  assign t     = shl - {1'b0, b_q};
  assign r_s   = t[32] ? shl[31:0] : t[31:0];
  assign q_s   = {q_q[30:0], ~t[32]};
  assign q_fin = negq_q ? -q_s : q_s;
  assign r_fin = negr_q ? -r_s : r_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (state_q)
      IDLE: begin
        if (!div_clear && div_enable) begin
          rem_d  = is_rem;
          negq_d = sgn & (div_rdata1[31] ^ div_rdata2[31]);
          negr_d = sgn & div_rdata1[31];
          b_d    = abs_b;
          r_d    = '0;
          q_d    = abs_a;
          cnt_d  = 5'd31;
          if (dz) begin
            state_d = DONE;
            res_d   = is_rem ? div_rdata1 : 32'hFFFF_FFFF;
          end else if (ovf) begin
            state_d = DONE;
            res_d   = is_rem ? 32'd0 : 32'h8000_0000;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (div_clear) begin
          state_d = IDLE;
        end else begin
          r_d   = r_s;
          q_d   = q_s;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_d = DONE;
            res_d   = rem_q ? r_fin : q_fin;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign div_result = res_q;
  assign div_ready  = (state_q == DONE);
  assign div_busy   = (state_q != IDLE);

endmodule
